// File: rtl/fp_accumulate_seq_if.sv
// Stream-in / sum-out handshake bundle for fp_accumulate_seq, plus the adder operand/result
// lines. The slave modport is the sequencer's view.
interface fp_accumulate_seq_if #(
  parameter int unsigned LEN_W = 8
);
  logic             start;
  logic [LEN_W-1:0] len;
  logic             in_valid;
  logic             in_ready;
  logic [31:0]      in_data;
  logic [31:0]      add_opa;
  logic [31:0]      add_opb;
  logic [31:0]      add_result;
  logic             out_valid;
  logic             out_ready;
  logic [31:0]      out_data;
  logic             out_special;
  logic             busy;

  modport master (
    output start, len, in_valid, in_data, add_result, out_ready,
    input  in_ready, add_opa, add_opb, out_valid, out_data, out_special, busy
  );

  modport slave (
    input  start, len, in_valid, in_data, add_result, out_ready,
    output in_ready, add_opa, add_opb, out_valid, out_data, out_special, busy
  );
endinterface

// File: rtl/fp_accumulate_seq.sv
// Sequencer that sums a stream of IEEE-754 singles through an external combinational adder,
// resolving zero, denormal, cancellation and Inf/NaN operands without using the adder.
module fp_accumulate_seq #(
  parameter int unsigned LEN_W = 8
) (
  input logic                 clk,
  input logic                 rst,
  fp_accumulate_seq_if.slave  bus
);

  typedef enum logic [2:0] {
    StIdle,
    StLoad,
    StFetch,
    StAdd,
    StDone
  } state_e;

  state_e           state_q, state_d;
  logic [31:0]      acc_q, acc_d;
  logic [31:0]      opb_q, opb_d;
  logic [LEN_W-1:0] rem_q, rem_d;
  logic             special_q, special_d;

  logic        in_ready;
  logic        hs;
  logic [31:0] op_n;
  logic        op_special;
  logic        acc_special;
  logic        cancel;

  assign in_ready    = (state_q == StLoad) || (state_q == StFetch);
  assign hs          = bus.in_valid && in_ready;
  // Zero and denormal operands both collapse to +0.
  assign op_n        = (bus.in_data[30:23] == 8'h00) ? 32'h0000_0000 : bus.in_data;
  assign op_special  = (op_n[30:23] == 8'hFF);
  assign acc_special = (acc_q[30:23] == 8'hFF);
  assign cancel      = (opb_q == {~acc_q[31], acc_q[30:0]});

  always_comb begin
    state_d   = state_q;
    acc_d     = acc_q;
    opb_d     = opb_q;
    rem_d     = rem_q;
    special_d = special_q;

    unique case (state_q)
      StIdle: begin
        if (bus.start) begin
          special_d = 1'b0;
          if (bus.len == '0) begin
            acc_d   = 32'h0000_0000;
            state_d = StDone;
          end else begin
            rem_d   = bus.len;
            state_d = StLoad;
          end
        end
      end

      StLoad: begin
        if (hs) begin
          acc_d     = op_n;
          special_d = op_special;
          rem_d     = rem_q - 1'b1;
          state_d   = (rem_q == LEN_W'(1)) ? StDone : StFetch;
        end
      end

      StFetch: begin
        if (hs) begin
          opb_d   = op_n;
          rem_d   = rem_q - 1'b1;
          state_d = (rem_q == LEN_W'(1)) ? StDone : StFetch;
          if (op_special) begin
            special_d = 1'b1;
          end
          // An Inf/NaN accumulator is sticky; everything after it is dropped.
          if (acc_special) begin
            acc_d = acc_q;
          end else if (op_special) begin
            acc_d = op_n;
          end else if (op_n == 32'h0000_0000) begin
            acc_d = acc_q;
          end else if (acc_q[30:0] == 31'h0) begin
            acc_d = op_n;
          end else begin
            state_d = StAdd;
          end
        end
      end

      StAdd: begin
        acc_d   = cancel ? 32'h0000_0000 : bus.add_result;
        state_d = (rem_q == '0) ? StDone : StFetch;
      end

      StDone: begin
        if (bus.out_ready) begin
          state_d = StIdle;
        end
      end

      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= StIdle;
      acc_q     <= 32'h0000_0000;
      opb_q     <= 32'h0000_0000;
      rem_q     <= '0;
      special_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      acc_q     <= acc_d;
      opb_q     <= opb_d;
      rem_q     <= rem_d;
      special_q <= special_d;
    end
  end

  assign bus.in_ready    = in_ready;
  assign bus.add_opa     = acc_q;
  assign bus.add_opb     = opb_q;
  assign bus.out_valid   = (state_q == StDone);
  assign bus.out_data    = (state_q == StDone) ? acc_q : 32'h0000_0000;
  assign bus.out_special = (state_q == StDone) && special_q;
  assign bus.busy        = (state_q != StIdle);

endmodule

// File: tb/tb_fp_accumulate_seq.sv
// Directed bench for fp_accumulate_seq with a lookup-table stand-in for the adder.
module tb_fp_accumulate_seq;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   cyc = 0;
  int   n_add = 0;
  int   total = 0;
  int   bad = 0;

  fp_accumulate_seq_if #(.LEN_W(8)) bus ();

  fp_accumulate_seq #(.LEN_W(8)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // ADD is the only busy state that neither accepts input nor presents a result.
  always @(negedge clk) begin
    if (bus.busy && !bus.in_ready && !bus.out_valid) n_add <= n_add + 1;
  end

  // Adder stand-in: only the sums these vectors need; the cancellation entry is deliberately
  // wrong so the sequencer's own +0 is what must appear.
  function automatic logic [31:0] fpa_stub(input logic [31:0] a, input logic [31:0] b);
    case ({a, b})
      {32'h3F80_0000, 32'h4000_0000}: return 32'h4040_0000;
      {32'h3F80_0000, 32'h3F80_0000}: return 32'h4000_0000;
      {32'h40A0_0000, 32'hC0A0_0000}: return 32'hDEAD_BEEF;
      default:                        return 32'h7FC0_0000;
    endcase
  endfunction

  always_comb bus.add_result = fpa_stub(bus.add_opa, bus.add_opb);

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic begin_sum(input logic [7:0] n);
    bus.len   = n;
    bus.start = 1'b1;
    @(posedge clk); #1;
    bus.start = 1'b0;
  endtask

  // Presents one operand and returns the cycle number in which it was accepted.
  task automatic send(input logic [31:0] d, output int at);
    int n;
    n = 0;
    bus.in_valid = 1'b1;
    bus.in_data  = d;
    @(negedge clk);
    while (!bus.in_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (!bus.in_ready) chk("send_timeout", {31'h0, bus.in_ready}, 32'd1);
    at = cyc;
    @(posedge clk); #1;
  endtask

  task automatic finish_sum(input string tag, input logic [31:0] exp_d, input logic exp_s,
                            output int at);
    int n;
    n = 0;
    @(negedge clk);
    while (!bus.out_valid && n < 50) begin
      @(negedge clk);
      n++;
    end
    at = cyc;
    chk({tag, "_valid"}, {31'h0, bus.out_valid}, 32'd1);
    chk({tag, "_data"}, bus.out_data, exp_d);
    chk({tag, "_special"}, {31'h0, bus.out_special}, {31'h0, exp_s});
    bus.out_ready = 1'b1;
    @(posedge clk); #1;
    bus.out_ready = 1'b0;
    chk({tag, "_drop"}, {31'h0, bus.out_valid}, 32'd0);
  endtask

  initial begin
    int t0;
    int t1;
    int td;
    int a0;

    bus.start     = 1'b0;
    bus.len       = '0;
    bus.in_valid  = 1'b0;
    bus.in_data   = '0;
    bus.out_ready = 1'b0;

    repeat (2) @(negedge clk);
    chk("rst_busy", {31'h0, bus.busy}, 32'd0);
    chk("rst_in_ready", {31'h0, bus.in_ready}, 32'd0);
    chk("rst_out_valid", {31'h0, bus.out_valid}, 32'd0);
    chk("rst_out_data", bus.out_data, 32'h0);
    chk("rst_opa", bus.add_opa, 32'h0);
    chk("rst_opb", bus.add_opb, 32'h0);
    rst = 1'b0;
    @(posedge clk); #1;

    // 1.0 + 2.0 = 3.0 through one ADD cycle
    a0 = n_add;
    begin_sum(8'd2);
    send(32'h3F80_0000, t0);
    send(32'h4000_0000, t1);
    bus.in_valid = 1'b0;
    chk("t1_opa", bus.add_opa, 32'h3F80_0000);
    chk("t1_opb", bus.add_opb, 32'h4000_0000);
    finish_sum("t1", 32'h4040_0000, 1'b0, td);
    chk("t1_latency", 32'(td - t0), 32'd3);
    chk("t1_adds", 32'(n_add - a0), 32'd1);

    // 5 + -5 cancels to +0, then +1.0 is copied straight in
    a0 = n_add;
    begin_sum(8'd3);
    send(32'h40A0_0000, t0);
    send(32'hC0A0_0000, t1);
    send(32'h3F80_0000, t1);
    bus.in_valid = 1'b0;
    finish_sum("t2", 32'h3F80_0000, 1'b0, td);
    chk("t2_adds", 32'(n_add - a0), 32'd1);

    // Zeros and a denormal are all +0; no adder use
    a0 = n_add;
    begin_sum(8'd4);
    send(32'h0000_0000, t0);
    send(32'h0000_0001, t1);
    send(32'h8000_0000, t1);
    send(32'h4120_0000, t1);
    bus.in_valid = 1'b0;
    finish_sum("t3", 32'h4120_0000, 1'b0, td);
    chk("t3_adds", 32'(n_add - a0), 32'd0);

    // +Inf sticks and flags special
    a0 = n_add;
    begin_sum(8'd3);
    send(32'h3F80_0000, t0);
    send(32'h7F80_0000, t1);
    send(32'h3F80_0000, t1);
    bus.in_valid = 1'b0;
    finish_sum("t4", 32'h7F80_0000, 1'b1, td);
    chk("t4_adds", 32'(n_add - a0), 32'd0);

    // Empty stream: +0 the next cycle, held while out_ready is low
    begin_sum(8'd0);
    @(negedge clk);
    chk("t5_valid_next", {31'h0, bus.out_valid}, 32'd1);
    chk("t5_data_next", bus.out_data, 32'h0);
    repeat (5) @(negedge clk);
    chk("t5_valid_held", {31'h0, bus.out_valid}, 32'd1);
    chk("t5_data_held", bus.out_data, 32'h0);
    @(posedge clk); #1;
    finish_sum("t5", 32'h0, 1'b0, td);

    // Reset in the middle of an ADD, then a fresh single-operand stream
    begin_sum(8'd5);
    send(32'h3F80_0000, t0);
    send(32'h3F80_0000, t1);
    bus.in_valid = 1'b0;
    chk("t6_add_in_ready", {31'h0, bus.in_ready}, 32'd0);
    chk("t6_add_busy", {31'h0, bus.busy}, 32'd1);
    rst = 1'b1;
    #1;
    chk("t6_rst_busy", {31'h0, bus.busy}, 32'd0);
    chk("t6_rst_out_valid", {31'h0, bus.out_valid}, 32'd0);
    chk("t6_rst_opa", bus.add_opa, 32'h0);
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk); #1;
    begin_sum(8'd1);
    send(32'h4040_0000, t0);
    bus.in_valid = 1'b0;
    finish_sum("t6", 32'h4040_0000, 1'b0, td);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule
